// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the user-I/O controller.
//   - FSM state encoding (IDLE, WAIT_PRESS, WAIT_RELEASE, DONE)
//   - hex7seg(): 4-bit nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}
package io_pkg;

    typedef logic [1:0] io_state_t;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE         = 2'd3;

    // Segment is lit when its bit is 0.
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-FF synchroniser plus debounce counter for one key.
//   A change on the synchronised key is accepted once it has differed from the
//   current stable level for CYCLES consecutive samples; any sample that agrees
//   with the stable level restarts the count.
// Ports:
//   clk       in   system clock
//   bt_reset  in   async reset, active-low
//   raw       in   raw key level, active-high
//   stable    out  debounced key level
//   rise      out  1-cycle pulse in the first cycle stable is 1
//   fall      out  1-cycle pulse in the first cycle stable is 0
module io_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic bt_reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt    <= '0;
                stable <= ~stable;
                rise   <= ~stable;
                fall   <= stable;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: user-I/O controller for the CPU.
//   IN  (inop):  stalls the CPU (await=1) until a debounced key press latches
//                the switches into du, then waits for the key to be released.
//   OUT (outop): on a CPU step, latches dm into dm_reg, which drives an
//                NUM_DIGITS-digit active-low hex 7-segment display.
// Optional feature, macro IO_TIMEOUT_EN: WAIT_PRESS gives up after
//   TIMEOUT_CYCLES cycles, writes du=0 and sets the sticky timeout flag.
// Ports:
//   clk       in   system clock (not the gated CPU clock)
//   bt_reset  in   async reset, active-low
//   step      in   1-cycle pulse: CPU clock advanced this cycle
//   inop      in   current instruction is IN
//   outop     in   current instruction is OUT
//   bt        in   raw key, active-high
//   in        in   [IN_W]          raw switches
//   dm        in   [DATA_W]        word to display on OUT
//   du        out  [DATA_W]        latched user input (zero-extended switches)
//   await     out  stall request to the CPU clock gate
//   timeout   out  sticky: last IN timed out (tied 0 without IO_TIMEOUT_EN)
//   display   out  [7*NUM_DIGITS]  active-low segments, digit 0 in the LSBs
module io_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int IN_W            = 14,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1 << 20
) (
    input  logic                    clk,
    input  logic                    bt_reset,
    input  logic                    step,
    input  logic                    inop,
    input  logic                    outop,
    input  logic                    bt,
    input  logic [IN_W-1:0]         in,
    input  logic [DATA_W-1:0]       dm,
    output logic [DATA_W-1:0]       du,
    output logic                    await,
    output logic                    timeout,
    output logic [7*NUM_DIGITS-1:0] display
);

    localparam int SHOW_W = 4 * NUM_DIGITS;

    io_state_t         state, state_nxt;
    logic [IN_W-1:0]   in_meta, in_sync;
    logic [DATA_W-1:0] dm_reg;
    logic              key_stable, press, release_evt;
    logic              captured;
    logic              to_hit;

    io_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk      (clk),
        .bt_reset (bt_reset),
        .raw      (bt),
        .stable   (key_stable),
        .rise     (press),
        .fall     (release_evt)
    );

    always_ff @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            in_meta <= '0;
            in_sync <= '0;
        end else begin
            in_meta <= in;
            in_sync <= in_meta;
        end
    end

    // Combinational from state only, so an async reset drops it immediately.
    assign await = (state == ST_WAIT_PRESS) || (state == ST_WAIT_RELEASE);

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (inop) state_nxt = key_stable ? ST_WAIT_RELEASE : ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
                if (press)       state_nxt = ST_WAIT_RELEASE;
                else if (to_hit) state_nxt = ST_DONE;
            end
            ST_WAIT_RELEASE: begin
                // A key already held when the IN began has captured nothing
                // yet: its release leads to a fresh wait for a press.
                if (release_evt) state_nxt = captured ? ST_DONE : ST_WAIT_PRESS;
            end
            ST_DONE: begin
                // Held until the CPU advances, so the still-asserted inop of
                // this same instruction cannot start a second IN.
                if (step) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            state    <= ST_IDLE;
            du       <= '0;
            captured <= 1'b0;
            dm_reg   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) captured <= 1'b0;
            if (state == ST_WAIT_PRESS && press) begin
                du       <= DATA_W'(in_sync);
                captured <= 1'b1;
            end else if (to_hit) begin
                du <= '0;
            end
            if (step && outop && !await) dm_reg <= dm;
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int              TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // A press in the same cycle as expiry wins.
    assign to_hit = (state == ST_WAIT_PRESS) && !press && (to_cnt == TO_MAX);

    always_ff @(posedge clk or negedge bt_reset) begin
        if (!bt_reset) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Held at zero outside WAIT_PRESS, so every entry starts from zero.
            if (state != ST_WAIT_PRESS) to_cnt <= '0;
            else if (!to_hit)           to_cnt <= to_cnt + TO_W'(1);
            if (to_hit)                                timeout_q <= 1'b1;
            else if (state == ST_WAIT_PRESS && press)  timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign display[7*i +: 7] = hex7seg(dm_reg[4*i +: 4]);
        end
        if (DATA_W > SHOW_W) begin : g_hidden
            // Upper word bits are held but never shown.
            logic unused_hidden;
            assign unused_hidden = ^dm_reg[DATA_W-1:SHOW_W];
        end
    endgenerate

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: randomized scoreboard bench for io_ctrl.
//   Stimulus tasks drive IN/OUT transactions and push the expected result of
//   each into a queue; a monitor pops and compares when the DUT presents it
//   (await falling for IN, the cycle after an OUT step for the display).
//   Define IO_TIMEOUT_EN for both DUT and bench to exercise the timeout path.
`timescale 1ns/1ps
module tb_io_ctrl;

    localparam int DATA_W = 32;
    localparam int IN_W   = 14;
    localparam int ND     = 4;
    localparam int DB     = 16;
    localparam int TO     = 64;

    // Active-low {g..a} patterns for 0-F.
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic                clk = 1'b0;
    logic                bt_reset = 1'b0;
    logic                step = 1'b0, inop = 1'b0, outop = 1'b0, bt = 1'b0;
    logic [IN_W-1:0]     in_v = '0;
    logic [DATA_W-1:0]   dm = '0;
    logic [DATA_W-1:0]   du;
    logic                await_s, timeout;
    logic [7*ND-1:0]     display;

    always #5 clk = ~clk;

    io_ctrl #(
        .DATA_W(DATA_W), .IN_W(IN_W), .NUM_DIGITS(ND),
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .bt_reset (bt_reset),
        .step     (step),
        .inop     (inop),
        .outop    (outop),
        .bt       (bt),
        .in       (in_v),
        .dm       (dm),
        .du       (du),
        .await    (await_s),
        .timeout  (timeout),
        .display  (display)
    );

    typedef struct packed {
        logic [DATA_W-1:0] du;
        logic              to;
    } in_exp_t;

    in_exp_t         in_q[$];
    logic [7*ND-1:0] disp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [DATA_W-1:0] model_dm = '0;
    logic [DATA_W-1:0] last_du  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7*ND-1:0] expect_display(input logic [DATA_W-1:0] w);
        logic [7*ND-1:0] r;
        logic [3:0]      nib;
        r = '0;
        for (int d = 0; d < ND; d++) begin
            nib = w[4*d +: 4];
            r[7*d +: 7] = SEG[nib];
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic    prev_await;
        in_exp_t e;
        prev_await = 1'b0;
        forever begin
            @(negedge clk);
            if (!bt_reset) begin
                prev_await = 1'b0;
            end else begin
                if (prev_await && !await_s) begin
                    if (in_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_in_completion: du %0h with no pending IN", du);
                    end else begin
                        e = in_q.pop_front();
                        check("in_du", du, e.du);
                        check("in_timeout", timeout, e.to);
                    end
                end
                prev_await = await_s;
                if (disp_q.size() != 0) check("display", display, disp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_await(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (await_s !== level && n < budget) begin
            tick(1);
            n++;
        end
        check(name, await_s, level);
    endtask

    task automatic do_out(input logic [DATA_W-1:0] word, input logic step_v, input logic blocked);
        step  = step_v;
        outop = 1'b1;
        dm    = word;
        tick(1);
        step  = 1'b0;
        outop = 1'b0;
        if (step_v && !blocked) model_dm = word;
        disp_q.push_back(expect_display(model_dm));
    endtask

    task automatic press_key(input int bounces);
        for (int i = 0; i < bounces; i++) begin
            bt = (i % 2 == 0);
            tick(1);
        end
        bt = 1'b1;
    endtask

    task automatic release_key(input int bounces);
        for (int i = 0; i < bounces; i++) begin
            bt = (i % 2 == 1);
            tick(1);
        end
        bt = 1'b0;
    endtask

    // One complete IN; keep_inop leaves inop high across DONE to check the hold.
    task automatic do_in(input logic [IN_W-1:0] value, input int bounces, input logic keep_inop);
        in_v = value;
        inop = 1'b1;
        tick(1);
        check("in_await_rise", await_s, 1'b1);
        in_q.push_back('{du: DATA_W'(value), to: 1'b0});
        last_du = DATA_W'(value);
        press_key(bounces);
        tick(22);
        in_v = IN_W'($urandom);          // must not be captured: key still held
        tick(4 + $urandom_range(0, 6));
        release_key($urandom_range(0, 4));
        wait_await(1'b0, 60, "in_await_fall");
        if (keep_inop) begin
            tick(10);
            check("done_hold_await", await_s, 1'b0);
            step = 1'b1;
            tick(1);
            step = 1'b0;
        end else begin
            step = 1'b1;
            inop = 1'b0;
            tick(1);
            step = 1'b0;
        end
        tick(2);
    endtask

    // ---------------- main sequence ----------------
    initial begin : stimulus
        tick(3);
        bt_reset = 1'b1;
        tick(1);
        check("reset_await", await_s, 1'b0);
        check("reset_du", du, '0);
        check("reset_timeout", timeout, 1'b0);
        check("reset_display", display, expect_display('0));

        // Directed IN with bounce.
        do_in(14'h1A5, 3, 1'b0);

        // OUT BEEF, then outop without step.
        do_out(32'h0000BEEF, 1'b1, 1'b0);
        tick(1);
        do_out(32'h00001234, 1'b0, 1'b0);
        tick(1);

        // Held key: pressed before the IN starts.
        bt = 1'b1;
        tick(25);
        in_v = 14'h0AA;
        inop = 1'b1;
        tick(1);
        check("held_await_rise", await_s, 1'b1);
        in_v = 14'h155;
        do_out(32'h00005678, 1'b1, 1'b1);   // OUT blocked while stalled
        tick(5);
        bt = 1'b0;
        tick(25);
        check("held_still_waiting", await_s, 1'b1);
        check("held_du_unchanged", du, last_du);
        in_v = 14'h3C7;
        in_q.push_back('{du: 32'h3C7, to: 1'b0});
        last_du = 32'h3C7;
        press_key(2);
        tick(22);
        in_v = 14'h0F0;
        tick(5);
        release_key(1);
        wait_await(1'b0, 60, "held_await_fall");
        step = 1'b1;
        inop = 1'b0;
        tick(1);
        step = 1'b0;
        tick(2);

        // DONE hold with inop left high, then a new IN from the step.
        do_in(IN_W'($urandom), 1, 1'b1);
        do_in(IN_W'($urandom), 0, 1'b0);

`ifdef IO_TIMEOUT_EN
        begin : timeout_test
            int n;
            inop = 1'b1;
            in_q.push_back('{du: '0, to: 1'b1});
            last_du = '0;
            tick(1);
            n = 0;
            while (await_s && n < 200) begin
                n++;
                tick(1);
            end
            check("timeout_stall_len", n, TO);
            step = 1'b1;
            inop = 1'b0;
            tick(1);
            step = 1'b0;
            tick(2);
            do_in(IN_W'($urandom), 2, 1'b0);   // press clears the flag
        end
`endif

        // Randomized mix.
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 2))
                0:       do_in(IN_W'($urandom), $urandom_range(0, 5), 1'b0);
                1:       begin do_out($urandom, 1'b1, 1'b0); tick(1); end
                default: begin do_out($urandom, 1'b0, 1'b0); tick(1); end
            endcase
        end

        // Reset in the middle of a wait.
        inop = 1'b1;
        in_v = 14'h2222;
        tick(1);
        bt = 1'b1;
        tick(25);
        bt_reset = 1'b0;
        #1;
        check("midreset_await", await_s, 1'b0);
        check("midreset_du", du, '0);
        bt   = 1'b0;
        inop = 1'b0;
        tick(3);
        bt_reset = 1'b1;
        model_dm = '0;
        tick(25);
        do_out(32'hFFFF_0000, 1'b0, 1'b0);
        tick(1);

        tick(3);
        check("scoreboard_drained", in_q.size() + disp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
